// File: rtl/uart_receiver.sv
// uart_receiver -- UART 8N1 receiver.
//
// Samples an asynchronous serial line, recovers each 8N1 character and
// presents it as a parallel byte with a one-cycle valid strobe. A stop bit
// sampled low is reported as a one-cycle frame_error pulse instead.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//
// Ports:
//   clock        system clock, all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   rx           serial line, idle high, asynchronous to clock
//   data         last correctly received byte, held until the next good one
//   valid        one-cycle pulse when data has just been updated
//   frame_error  one-cycle pulse when a stop bit was sampled low
//   busy         high whenever the receiver is not idle
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    // Compare points for the bit-period counter: end of a full bit period,
    // and the middle of the start bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       sh_reg, sh_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;
    logic [1:0]       sync_reg;
    logic             rxs;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs = sync_reg[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            sh_reg    <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            sh_reg    <= sh_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        sh_next    = sh_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end

            START: begin
                // Re-check the line at mid start bit; a high level here means
                // the falling edge was a glitch and the frame is abandoned.
                if (cnt_reg == CNT_MID) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DATA: begin
                // Counting started at mid start bit, so a full period later
                // lands in the centre of each data bit.
                if (cnt_reg == CNT_LAST) begin
                    sh_next  = {rxs, sh_reg[7:1]};
                    cnt_next = '0;
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            STOP: begin
                // Leave at mid stop bit so an immediately following start bit
                // is still caught.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxs) begin
                        data_next  = sh_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign data        = data_reg;
    assign valid       = valid_reg;
    assign frame_error = ferr_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- self-checking bench for uart_receiver at 16 clocks/bit.
//
// A bit-accurate line driver sends frames; every frame it sends queues the
// event the receiver must report (good byte or framing error) together with
// the cycle it is due. A single per-cycle check matches DUT pulses against
// that queue and checks that data always holds the last good byte.
module tb_uart_receiver;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam int T = 2 + H + 9 * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       busy;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        int         due;
    } ev_t;

    ev_t        q[$];
    logic [7:0] rxlog[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] last_good  = 8'h00;
    int         npulse     = 0;
    int         last_pulse = 0;
    int         prev_pulse = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and check the outputs on the falling edge.
    task automatic tick();
        ev_t e;
        @(negedge clock);
        if (reset) begin
            chk("reset_outputs", {21'd0, data, valid, frame_error, busy}, 32'd0);
        end else begin
            if (valid || frame_error) begin
                npulse++;
                prev_pulse = last_pulse;
                last_pulse = cyc;
                chk("valid_and_ferr_exclusive", {31'd0, valid && frame_error}, 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, valid, frame_error}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind_ferr", {31'd0, frame_error}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        last_good = e.b;
                        rxlog.push_back(data);
                    end
                    chk("pulse_latency_window",
                        {31'd0, (cyc >= e.due - 1) && (cyc <= e.due + 1)}, 32'd1);
                end
            end
            if (q.size() > 0 && cyc > q[0].due + 1) begin
                chk("missed_pulse_at", cyc, q[0].due);
                void'(q.pop_front());
            end
            chk("data_hold", {24'd0, data}, {24'd0, last_good});
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.is_err = !stop_ok;
        e.b      = b;
        e.due    = cyc + T;
        q.push_back(e);
        drive_bit(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bit(b[i], C);
        drive_bit(stop_ok, C);
        rx = 1'b1;
    endtask

    initial begin
        int         n0;
        int         busy_cnt;
        logic [7:0] str[3];

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        idle(10);
        chk("after_reset_data", {24'd0, data}, 32'h00);
        chk("after_reset_busy", {31'd0, busy}, 32'd0);

        // Single byte
        n0 = npulse;
        send_frame(8'h55, 1'b1);
        idle(10);
        chk("single_pulses", npulse - n0, 32'd1);
        chk("single_data_lit", {24'd0, data}, 32'h55);
        chk("single_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no idle gap
        n0 = npulse;
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        idle(10);
        chk("b2b_pulses", npulse - n0, 32'd2);
        chk("b2b_spacing", last_pulse - prev_pulse, 32'd160);
        chk("b2b_data_lit", {24'd0, data}, 32'h69);

        // Glitch: short low pulse must be rejected
        n0 = npulse;
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("glitch_no_pulse", npulse - n0, 32'd0);
        chk("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        chk("glitch_busy_bounded", {31'd0, busy_cnt <= H + 2}, 32'd1);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);

        // Framing error after a good byte
        send_frame(8'h48, 1'b1);
        n0 = npulse;
        send_frame(8'hA5, 1'b0);
        idle(40);
        chk("ferr_pulses", npulse - n0, 32'd1);
        chk("ferr_data_kept_lit", {24'd0, data}, 32'h48);

        // Reset during data bit 4 of 8'hFF
        drive_bit(1'b0, C);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, C);
        drive_bit(1'b1, C / 2);
        chk("midframe_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midframe_async_clear", {21'd0, data, valid, frame_error, busy}, 32'd0);
        last_good = 8'h00;
        q.delete();
        repeat (3) tick();
        reset = 1'b0;
        idle(20);
        n0 = npulse;
        send_frame(8'hA5, 1'b1);
        idle(10);
        chk("post_reset_pulses", npulse - n0, 32'd1);
        chk("post_reset_data_lit", {24'd0, data}, 32'hA5);

        // String sent back-to-back, as a transmitter would
        str[0] = 8'h48;
        str[1] = 8'h69;
        str[2] = 8'h21;
        rxlog.delete();
        for (int i = 0; i < 3; i++) send_frame(str[i], 1'b1);
        idle(20);
        chk("string_len", rxlog.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rxlog.size()) chk("string_byte", {24'd0, rxlog[i]}, {24'd0, str[i]});
        end

        chk("events_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
